// File: rtl/fifo_pkg.sv
// Shared types for the fifo read-side packer: flush FSM states and keep-mask helper.
package fifo_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    EMIT  = 2'd2
  } state_t;

  localparam int unsigned MASK_W = 32;

  // Lowest n bits set; callers slice down to their own word count.
  function automatic logic [MASK_W-1:0] mask_lo(input int unsigned n);
    logic [MASK_W-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MASK_W; i++) begin
      if (i < n) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/stream_out_reg.sv
// Single-entry valid/ready holding register carrying data, keep mask and last flag.
module stream_out_reg #(
  parameter int DW = 32,
  parameter int KW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [DW-1:0] load_data,
  input  logic [KW-1:0] load_keep,
  input  logic          load_last,
  input  logic          ready,
  output logic          valid,
  output logic [DW-1:0] data,
  output logic [KW-1:0] keep,
  output logic          last
);

  // The parent only asserts load when the slot is empty or being drained this edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
      keep  <= '0;
      last  <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
      keep  <= load_keep;
      last  <= load_last;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fifo_rd_packer.sv
// Reads a one-cycle-latency fifo, packs PACK words per output beat, supports flush of a partial beat.
module fifo_rd_packer
  import fifo_pkg::*;
#(
  parameter int WORD_SIZE = 8,
  parameter int PACK      = 4,
  parameter int CNT_W     = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      fifo_empty,
  output logic                      fifo_re,
  input  logic [WORD_SIZE-1:0]      fifo_rdata,
  input  logic                      flush,
  output logic                      flush_done,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [PACK*WORD_SIZE-1:0] m_data,
  output logic [PACK-1:0]           m_keep,
  output logic                      m_last,
  output logic [CNT_W-1:0]          beat_cnt
);

  localparam int AW = $clog2(PACK + 1);
  localparam int BW = PACK * WORD_SIZE;
  localparam logic [AW-1:0] PACK_A = AW'(PACK);
  localparam logic [AW-1:0] LAST_A = AW'(PACK - 1);
  localparam logic [AW:0]   PACK_F = (AW + 1)'(PACK);

  state_t                             state;
  logic [AW-1:0]                      asm_cnt;
  logic                               rd_pend;
  logic [PACK-1:0][WORD_SIZE-1:0]     slots;
  logic [PACK-1:0][WORD_SIZE-1:0]     slots_nx;
  logic [AW:0]                        fill;
  logic                               out_can_load;
  logic                               full_load;
  logic                               part_load;
  logic [MASK_W-1:0]                  keep_wide;
  logic                               unused_mask;
  logic [PACK-1:0]                    beat_keep;
  logic [BW-1:0]                      beat_data;

  assign out_can_load = !m_valid || m_ready;
  // Word count once this edge's in-flight read lands.
  assign fill = {1'b0, asm_cnt} + {{AW{1'b0}}, rd_pend};

  // The last-slot read is allowed only when the beat it completes can leave on the same edge.
  assign fifo_re = !rst && !fifo_empty && (state == RUN) && !flush &&
                   ((fill < PACK_F) ||
                    ((fill == PACK_F) && rd_pend && (asm_cnt == LAST_A) && out_can_load));

  assign full_load = (fill == PACK_F) && out_can_load;
  // rd_pend is always clear in EMIT, so asm_cnt is the settled word count there.
  assign part_load = (state == EMIT) && (asm_cnt != '0) && (asm_cnt != PACK_A) && out_can_load;

  assign keep_wide   = mask_lo(32'(asm_cnt));
  assign unused_mask = ^keep_wide;

  always_comb begin
    slots_nx = slots;
    for (int i = 0; i < PACK; i++) begin
      if (rd_pend && (asm_cnt == AW'(i))) slots_nx[i] = fifo_rdata;
    end
  end

  always_comb begin
    beat_keep = part_load ? keep_wide[PACK-1:0] : '1;
    beat_data = '0;
    for (int i = 0; i < PACK; i++) begin
      beat_data[i*WORD_SIZE +: WORD_SIZE] = beat_keep[i] ? slots_nx[i] : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      asm_cnt    <= '0;
      rd_pend    <= 1'b0;
      slots      <= '0;
      flush_done <= 1'b0;
      beat_cnt   <= '0;
    end else begin
      rd_pend    <= fifo_re;
      slots      <= slots_nx;
      flush_done <= 1'b0;
      asm_cnt    <= (full_load || part_load) ? '0 : fill[AW-1:0];
      if (m_valid && m_ready) beat_cnt <= beat_cnt + CNT_W'(1);

      case (state)
        RUN: begin
          if (flush) state <= DRAIN;
        end
        DRAIN: begin
          if (!rd_pend) state <= EMIT;
        end
        EMIT: begin
          // A full assembly leaves through the normal load path before the flush completes.
          if (asm_cnt == '0 || part_load) begin
            flush_done <= 1'b1;
            state      <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  stream_out_reg #(
    .DW(BW),
    .KW(PACK)
  ) u_out (
    .clk      (clk),
    .rst      (rst),
    .load     (full_load || part_load),
    .load_data(beat_data),
    .load_keep(beat_keep),
    .load_last(part_load),
    .ready    (m_ready),
    .valid    (m_valid),
    .data     (m_data),
    .keep     (m_keep),
    .last     (m_last)
  );

endmodule
